// File: rtl/endec_axis_frame_loader.sv
// AXI4-Stream front end for endec_interface: parses a header word, packs payload
// words into the encoder or decoder frame and hands the frame over with valid/ready.
module endec_axis_frame_loader #(
  parameter int MAX_CONSTRAINT_LENGTH = 9,
  parameter int MAX_CODE_RATE         = 3,
  parameter int ERR_CNT_W             = 8
) (
  input  logic                                           sys_clk,
  input  logic                                           rst,
  input  logic [31:0]                                    s_axis_tdata,
  input  logic                                           s_axis_tvalid,
  input  logic                                           s_axis_tlast,
  output logic                                           s_axis_tready,
  output logic                                           o_code_rate,
  output logic                                           o_mode_sel,
  output logic [MAX_CONSTRAINT_LENGTH*MAX_CODE_RATE-1:0] o_gen_poly_flat,
  output logic [127:0]                                   o_encoder_data_frame,
  output logic [383:0]                                   o_decoder_data_frame,
  output logic                                           o_frame_valid,
  input  logic                                           i_frame_ready,
  output logic                                           o_frame_err,
  output logic [ERR_CNT_W-1:0]                           o_err_count
);

  localparam int POLY_W    = MAX_CONSTRAINT_LENGTH * MAX_CODE_RATE;
  localparam int ENC_WORDS = 4;
  localparam int DEC_WORDS = 12;

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DRAIN, S_OUT} state_t;

  state_t                state_reg;
  logic [3:0]            word_cnt_reg;
  logic                  code_rate_reg;
  logic                  mode_sel_reg;
  logic [POLY_W-1:0]     gen_poly_reg;
  logic [31:0]           enc_words_reg [ENC_WORDS];
  logic [31:0]           dec_words_reg [DEC_WORDS];
  logic                  frame_valid_reg;
  logic                  frame_err_reg;
  logic [ERR_CNT_W-1:0]  err_count_reg;

  logic                  accept;
  logic                  hdr_accept;
  logic                  pay_accept;
  logic [3:0]            last_idx;
  logic                  is_last_word;
  logic                  err_pulse;
  logic                  unused_hdr_bits;

  assign s_axis_tready   = !rst && (state_reg != S_OUT);
  assign accept          = s_axis_tvalid && s_axis_tready;
  assign hdr_accept      = accept && (state_reg == S_HDR);
  assign pay_accept      = accept && (state_reg == S_PAYLOAD);
  assign unused_hdr_bits = ^s_axis_tdata[31:29];

  assign last_idx     = mode_sel_reg ? (code_rate_reg ? 4'd11 : 4'd7) : 4'd3;
  assign is_last_word = (word_cnt_reg == last_idx);

  // Malformed: tlast on the header, tlast before the last word, or no tlast on it.
  assign err_pulse = (hdr_accept && s_axis_tlast) ||
                     (pay_accept && (is_last_word != s_axis_tlast));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg       <= S_HDR;
      word_cnt_reg    <= '0;
      code_rate_reg   <= 1'b0;
      mode_sel_reg    <= 1'b0;
      gen_poly_reg    <= '0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      err_count_reg   <= '0;
    end else begin
      frame_err_reg <= err_pulse;
      if (err_pulse && (err_count_reg != {ERR_CNT_W{1'b1}}))
        err_count_reg <= err_count_reg + 1'b1;

      case (state_reg)
        S_HDR: begin
          if (accept) begin
            code_rate_reg <= s_axis_tdata[0];
            mode_sel_reg  <= s_axis_tdata[1];
            gen_poly_reg  <= s_axis_tdata[2 +: POLY_W];
            word_cnt_reg  <= '0;
            state_reg     <= s_axis_tlast ? S_HDR : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            word_cnt_reg <= word_cnt_reg + 4'd1;
            if (is_last_word) begin
              state_reg       <= s_axis_tlast ? S_OUT : S_DRAIN;
              frame_valid_reg <= s_axis_tlast;
            end else if (s_axis_tlast) begin
              state_reg <= S_HDR;
            end
          end
        end
        S_DRAIN: begin
          if (accept && s_axis_tlast)
            state_reg <= S_HDR;
        end
        S_OUT: begin
          if (i_frame_ready) begin
            frame_valid_reg <= 1'b0;
            state_reg       <= S_HDR;
          end
        end
        default: state_reg <= S_HDR;
      endcase
    end
  end

  // One register slot per payload word; a new header clears every slot.
  generate
    for (genvar gi = 0; gi < ENC_WORDS; gi++) begin : g_enc
      always_ff @(posedge sys_clk) begin
        if (rst || hdr_accept)
          enc_words_reg[gi] <= '0;
        else if (pay_accept && !mode_sel_reg && (word_cnt_reg == 4'(gi)))
          enc_words_reg[gi] <= s_axis_tdata;
      end
      assign o_encoder_data_frame[32*gi +: 32] = enc_words_reg[gi];
    end

    for (genvar gi = 0; gi < DEC_WORDS; gi++) begin : g_dec
      always_ff @(posedge sys_clk) begin
        if (rst || hdr_accept)
          dec_words_reg[gi] <= '0;
        else if (pay_accept && mode_sel_reg && (word_cnt_reg == 4'(gi)))
          dec_words_reg[gi] <= s_axis_tdata;
      end
      assign o_decoder_data_frame[32*gi +: 32] = dec_words_reg[gi];
    end
  endgenerate

  assign o_code_rate     = code_rate_reg;
  assign o_mode_sel      = mode_sel_reg;
  assign o_gen_poly_flat = gen_poly_reg;
  assign o_frame_valid   = frame_valid_reg;
  assign o_frame_err     = frame_err_reg;
  assign o_err_count     = err_count_reg;

endmodule

// File: tb/tb_endec_axis_frame_loader.sv
// Scoreboard bench for endec_axis_frame_loader: expected frames are queued when a
// packet is driven and compared when the loader presents the frame.
module tb_endec_axis_frame_loader;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tready;
  logic         o_code_rate;
  logic         o_mode_sel;
  logic [26:0]  o_gen_poly_flat;
  logic [127:0] o_encoder_data_frame;
  logic [383:0] o_decoder_data_frame;
  logic         o_frame_valid;
  logic         i_frame_ready;
  logic         o_frame_err;
  logic [7:0]   o_err_count;

  always #5 sys_clk = ~sys_clk;

  endec_axis_frame_loader dut (
    .sys_clk              (sys_clk),
    .rst                  (rst),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tlast         (s_axis_tlast),
    .s_axis_tready        (s_axis_tready),
    .o_code_rate          (o_code_rate),
    .o_mode_sel           (o_mode_sel),
    .o_gen_poly_flat      (o_gen_poly_flat),
    .o_encoder_data_frame (o_encoder_data_frame),
    .o_decoder_data_frame (o_decoder_data_frame),
    .o_frame_valid        (o_frame_valid),
    .i_frame_ready        (i_frame_ready),
    .o_frame_err          (o_frame_err),
    .o_err_count          (o_err_count)
  );

  typedef struct {
    logic         cr;
    logic         md;
    logic [26:0]  poly;
    logic [127:0] enc;
    logic [383:0] dec;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   valid_rises = 0;
  logic valid_d = 1'b0;

  always @(posedge sys_clk) begin
    valid_d <= o_frame_valid;
    if (o_frame_valid && !valid_d)
      valid_rises <= valid_rises + 1;
  end

  task automatic check_val(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the handshake edge.
  task automatic send_word(input logic [31:0] d, input logic l);
    int budget;
    @(negedge sys_clk);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = l;
    budget = 0;
    while (!s_axis_tready && budget < 50) begin
      @(negedge sys_clk);
      budget++;
    end
    if (!s_axis_tready) check_val("tready_timeout", s_axis_tready, 1);
    @(posedge sys_clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // last_at: 1-based payload word carrying tlast (0 = on the header itself).
  task automatic send_pkt(input logic [31:0] hdr, input int n, input logic [31:0] base,
                          input int last_at, input int stall_at, input bit ok);
    exp_t e;
    int n_exp;
    logic [31:0] w;
    e.cr   = hdr[0];
    e.md   = hdr[1];
    e.poly = hdr[28:2];
    e.enc  = '0;
    e.dec  = '0;
    n_exp  = e.md ? (e.cr ? 12 : 8) : 4;
    for (int k = 0; k < n; k++) begin
      w = (base == 0) ? 32'h11111111 * (k + 1) : base + k;
      if (k < n_exp) begin
        if (e.md) e.dec[32*k +: 32] = w;
        else      e.enc[32*k +: 32] = w;
      end
    end
    if (ok) sb_q.push_back(e);
    send_word(hdr, last_at == 0);
    check_val("hdr_err", o_frame_err, last_at == 0);
    for (int k = 1; k <= n; k++) begin
      if (k - 1 == stall_at) repeat (3) @(negedge sys_clk);
      w = (base == 0) ? 32'h11111111 * k : base + k - 1;
      send_word(w, k == last_at);
      check_val($sformatf("word%0d_err", k), o_frame_err,
                (k == n_exp && k != last_at) || (k < n_exp && k == last_at));
    end
  endtask

  task automatic take_frame(input int hold);
    exp_t e;
    check_val("latency_valid", o_frame_valid, 1);
    check_val("sb_depth", sb_q.size(), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    $display("frame rx: mode=%0d rate=%0d poly=%0h enc=%0h", o_mode_sel, o_code_rate,
             o_gen_poly_flat, o_encoder_data_frame);
    check_val("code_rate", o_code_rate, e.cr);
    check_val("mode_sel", o_mode_sel, e.md);
    check_val("gen_poly", o_gen_poly_flat, e.poly);
    check_val("enc_frame", o_encoder_data_frame, e.enc);
    check_val("dec_frame", o_decoder_data_frame, e.dec);
    check_val("tready_out", s_axis_tready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge sys_clk);
      check_val("hold_valid", o_frame_valid, 1);
      check_val("hold_tready", s_axis_tready, 0);
      check_val("hold_enc", o_encoder_data_frame, e.enc);
      check_val("hold_dec", o_decoder_data_frame, e.dec);
    end
    @(negedge sys_clk);
    i_frame_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    check_val("valid_drop", o_frame_valid, 0);
    check_val("tready_back", s_axis_tready, 1);
    @(negedge sys_clk);
    i_frame_ready = 1'b0;
  endtask

  initial begin
    int r0;
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    i_frame_ready = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_val("rst_tready", s_axis_tready, 0);
    check_val("rst_valid", o_frame_valid, 0);
    check_val("rst_errcnt", o_err_count, 0);
    @(negedge sys_clk);
    rst = 1'b0;

    // Encode packet, backpressured for 10 cycles
    send_pkt(32'h0000281C, 4, 0, 4, -1, 1);
    take_frame(10);

    // Decode rate 1/2: upper third of the decoder frame stays zero
    send_pkt(32'h0000281E, 8, 32'hA0000000, 8, -1, 1);
    check_val("dec12_upper", o_decoder_data_frame[383:256], 0);
    take_frame(0);

    // Decode rate 1/3 with a 3-cycle stall mid-packet
    r0 = valid_rises;
    send_pkt(32'h0000281F, 12, 32'hB0000000, 12, 5, 1);
    take_frame(2);
    repeat (3) @(negedge sys_clk);
    check_val("dec13_once", valid_rises - r0, 1);

    // Early tlast, then a clean packet
    r0 = valid_rises;
    send_pkt(32'h0000281C, 2, 32'hC0000000, 2, -1, 0);
    repeat (2) @(negedge sys_clk);
    check_val("early_errcnt", o_err_count, 1);
    check_val("early_novalid", valid_rises - r0, 0);
    send_pkt(32'h0000281C, 4, 32'hC1000000, 4, -1, 1);
    take_frame(0);

    // Missing tlast: words 5-6 drained, next header parses
    send_pkt(32'h0000281C, 6, 32'hD0000000, 6, -1, 0);
    check_val("drain_tready", s_axis_tready, 1);
    check_val("missing_errcnt", o_err_count, 2);
    send_pkt(32'h0000A3CA, 8, 32'hD1000000, 8, -1, 1);
    take_frame(0);

    // Header-only packet with tlast
    send_pkt(32'h0000281C, 0, 0, 0, -1, 0);
    check_val("hdr_tlast_errcnt", o_err_count, 3);

    // Reset mid-payload
    send_pkt(32'h0000281F, 3, 32'hE0000000, 99, -1, 0);
    @(negedge sys_clk);
    rst = 1'b1;
    #1;
    check_val("rst_mid_tready", s_axis_tready, 0);
    @(posedge sys_clk);
    #1;
    check_val("rst_mid_rate", o_code_rate, 0);
    check_val("rst_mid_mode", o_mode_sel, 0);
    check_val("rst_mid_poly", o_gen_poly_flat, 0);
    check_val("rst_mid_dec", o_decoder_data_frame, 0);
    check_val("rst_mid_enc", o_encoder_data_frame, 0);
    check_val("rst_mid_valid", o_frame_valid, 0);
    check_val("rst_mid_err", o_frame_err, 0);
    check_val("rst_mid_errcnt", o_err_count, 0);
    @(negedge sys_clk);
    rst = 1'b0;

    // Error counter saturation
    for (int i = 0; i < 256; i++) send_pkt(32'h0000281C, 0, 0, 0, -1, 0);
    check_val("errcnt_sat", o_err_count, 255);
    send_pkt(32'h1000281C, 4, 32'hF0000000, 4, -1, 1);
    take_frame(1);
    check_val("errcnt_hold", o_err_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
